melody_sequencer: RTL and testbench

Plays a fixed melody stored in an internal note ROM. For each entry it presents a 6-bit note code and a gate for a fixed number of beats. The note code is octave×12 + semitone, with A as semitone 0. The block sits directly upstream of the square-wave tone generator: `fullnote` drives the generator's divide-by-12 input, and `gate` enables the speaker output.

---
 rtl/melody_pkg.sv | 76 +++++++
 rtl/melody_sequencer_if.sv | 16 +
 rtl/melody_rom.sv | 19 +
 rtl/melody_sequencer.sv | 127 ++++++++++++
 tb/tb_melody_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/melody_pkg.sv
// Shared types, widths, semitone names and the song table for the melody sequencer.
package melody_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_DONE
  } state_e;

  localparam int NOTE_W  = 6;
  localparam int DUR_W   = 3;
  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic              rest;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  localparam logic [3:0] SEMI_A  = 4'd0;
  localparam logic [3:0] SEMI_AS = 4'd1;
  localparam logic [3:0] SEMI_B  = 4'd2;
  localparam logic [3:0] SEMI_C  = 4'd3;
  localparam logic [3:0] SEMI_CS = 4'd4;
  localparam logic [3:0] SEMI_D  = 4'd5;
  localparam logic [3:0] SEMI_DS = 4'd6;
  localparam logic [3:0] SEMI_E  = 4'd7;
  localparam logic [3:0] SEMI_F  = 4'd8;
  localparam logic [3:0] SEMI_FS = 4'd9;
  localparam logic [3:0] SEMI_G  = 4'd10;
  localparam logic [3:0] SEMI_GS = 4'd11;

  function automatic entry_t mk_note(input int unsigned octave, input logic [3:0] semi,
                                     input int unsigned beats);
    entry_t e;
    e.rest = 1'b0;
    e.note = NOTE_W'(octave * 12 + int'(semi));
    e.dur  = DUR_W'(beats - 1);
    return e;
  endfunction

  function automatic entry_t mk_rest(input int unsigned beats);
    entry_t e;
    e.rest = 1'b1;
    e.note = '0;
    e.dur  = DUR_W'(beats - 1);
    return e;
  endfunction

  // Entries past the end of the tune are silent one-beat rests.
  function automatic entry_t song_entry(input logic [7:0] idx);
    entry_t e;
    case (idx)
      8'd0:  e = mk_note(0, SEMI_C, 1);  8'd1:  e = mk_note(1, SEMI_C, 2);
      8'd2:  e = mk_rest(1);             8'd3:  e = mk_note(2, SEMI_E, 1);
      8'd4:  e = mk_note(2, SEMI_E, 1);  8'd5:  e = mk_note(2, SEMI_F, 1);
      8'd6:  e = mk_note(2, SEMI_G, 1);  8'd7:  e = mk_note(2, SEMI_G, 1);
      8'd8:  e = mk_note(2, SEMI_F, 1);  8'd9:  e = mk_note(2, SEMI_E, 1);
      8'd10: e = mk_note(2, SEMI_D, 1);  8'd11: e = mk_note(2, SEMI_C, 1);
      8'd12: e = mk_note(2, SEMI_C, 1);  8'd13: e = mk_note(2, SEMI_D, 1);
      8'd14: e = mk_note(2, SEMI_E, 1);  8'd15: e = mk_note(2, SEMI_E, 2);
      8'd16: e = mk_note(2, SEMI_D, 1);  8'd17: e = mk_note(2, SEMI_D, 2);
      8'd18: e = mk_rest(2);             8'd19: e = mk_note(2, SEMI_E, 1);
      8'd20: e = mk_note(2, SEMI_E, 1);  8'd21: e = mk_note(2, SEMI_F, 1);
      8'd22: e = mk_note(2, SEMI_G, 1);  8'd23: e = mk_note(2, SEMI_G, 1);
      8'd24: e = mk_note(2, SEMI_F, 1);  8'd25: e = mk_note(2, SEMI_E, 1);
      8'd26: e = mk_note(2, SEMI_D, 1);  8'd27: e = mk_note(2, SEMI_C, 1);
      8'd28: e = mk_note(2, SEMI_C, 1);  8'd29: e = mk_note(2, SEMI_D, 1);
      8'd30: e = mk_note(2, SEMI_E, 1);  8'd31: e = mk_note(2, SEMI_D, 4);
      default: e = mk_rest(1);
    endcase
    return e;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control and audio-output bundle between a controller (master) and the melody sequencer (slave).
interface melody_sequencer_if
  import melody_pkg::*;
();
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [NOTE_W-1:0] fullnote;
  logic              gate;
  logic              busy;
  logic              beat;
  logic              done;

  modport master (output start, stop, loop_en, input fullnote, gate, busy, beat, done);
  modport slave  (input start, stop, loop_en, output fullnote, gate, busy, beat, done);
endinterface

// File: rtl/melody_rom.sv
// 256 x 10-bit song ROM with a registered (one-cycle latency) read port.
module melody_rom
  import melody_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr_i,
  output entry_t     data_o
);

  entry_t data_q;

  // NOTE: the read register has no reset; its value is only consumed the cycle after an address is presented.
  always_ff @(posedge clk) begin
    data_q <= song_entry(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM, presenting note code and gate for (dur+1) beats per entry.
// Define MELODY_SEQ_GAP_EN to silence the last GAP_TICKS cycles of every sounding entry.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned TEMPO_DIV = 12_000_000,
  parameter int unsigned SONG_LEN  = 32,
  parameter int unsigned GAP_TICKS = 600_000
) (
  input logic               clk,
  input logic               rst,
  melody_sequencer_if.slave seq_if
);

  localparam int unsigned       TICK_W      = $clog2(TEMPO_DIV);
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TEMPO_DIV - 1);
  localparam logic [7:0]        LAST_ADDR   = 8'(SONG_LEN - 1);
`ifdef MELODY_SEQ_GAP_EN
  localparam logic [TICK_W-1:0] GAP_LIMIT   = TICK_W'(GAP_TICKS);
`endif

  state_e            state_q;
  logic [7:0]        addr_q, addr_d;
  logic [TICK_W-1:0] tick_q;
  logic [DUR_W-1:0]  beat_cnt_q;
  logic [NOTE_W-1:0] fullnote_q;
  logic              gate_q, busy_q, beat_q, done_q;
  logic              last_entry, entry_end;
  entry_t            rom_data;

  // The ROM is addressed with the next address so its data is ready during FETCH.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    last_entry = (addr_q == LAST_ADDR);
    entry_end  = (state_q == ST_PLAY) && (tick_q == '0) && (beat_cnt_q == '0);
    addr_d     = addr_q;
    if (!seq_if.stop) begin
      if ((state_q == ST_IDLE || state_q == ST_DONE) && seq_if.start) begin
        addr_d = '0;
      end else if (entry_end) begin
        addr_d = last_entry ? '0 : addr_q + 8'd1;
      end
    end
  end

  melody_rom u_rom (
    .clk    (clk),
    .addr_i (addr_d),
    .data_o (rom_data)
  );

  // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tick_q     <= '0;
      beat_cnt_q <= '0;
      fullnote_q <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      beat_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q <= addr_d;
      beat_q <= 1'b0;
      done_q <= 1'b0;
      if (seq_if.stop) begin
        state_q <= ST_IDLE;
        gate_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (seq_if.start) begin
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
            end
          end
          ST_FETCH: begin
            state_q    <= ST_PLAY;
            fullnote_q <= rom_data.note;
            gate_q     <= ~rom_data.rest;
            tick_q     <= TICK_RELOAD;
            beat_cnt_q <= rom_data.dur;
          end
          ST_PLAY: begin
            if (tick_q != '0) begin
              tick_q <= tick_q - 1'b1;
              beat_q <= (tick_q == TICK_W'(1));
`ifdef MELODY_SEQ_GAP_EN
              if (beat_cnt_q == '0 && tick_q <= GAP_LIMIT) gate_q <= 1'b0;
`endif
            end else if (beat_cnt_q != '0) begin
              beat_cnt_q <= beat_cnt_q - 1'b1;
              tick_q     <= TICK_RELOAD;
            end else if (!last_entry || seq_if.loop_en) begin
              state_q <= ST_FETCH;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              gate_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            gate_q <= 1'b0;
            if (seq_if.start) begin
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign seq_if.fullnote = fullnote_q;
  assign seq_if.gate     = gate_q;
  assign seq_if.busy     = busy_q;
  assign seq_if.beat     = beat_q;
  assign seq_if.done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench: directed scenarios plus random start/stop/loop traffic against a timeline model.
module tb_melody_sequencer;

  localparam int TD  = 4;
  localparam int SL  = 3;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  melody_sequencer_if sif ();

  melody_sequencer #(
    .TEMPO_DIV (TD),
    .SONG_LEN  (SL),
    .GAP_TICKS (GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (sif)
  );

  always #5 clk = ~clk;

  // Expected song contents for the first SL entries.
  int song_note [SL] = '{3, 15, 0};
  int song_dur  [SL] = '{0, 1, 0};
  bit song_rest [SL] = '{1'b0, 1'b0, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_t counts cycles since the first FETCH of a pass through the song.
  bit m_run;
  int m_t;
  int song_t;
  int exp_fn;
  bit exp_gate, exp_busy, exp_beat, exp_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_t      = 0;
    exp_fn   = 0;
    exp_gate = 1'b0;
    exp_busy = 1'b0;
    exp_beat = 1'b0;
    exp_done = 1'b0;
  endtask

  // Derive outputs from the position within the song timeline; FETCH cycles keep note and gate.
  task automatic model_outputs();
    int t, k, play_len, j;
    t = m_t;
    k = 0;
    while (t >= (song_dur[k] + 1) * TD + 1) begin
      t -= (song_dur[k] + 1) * TD + 1;
      k++;
    end
    exp_busy = 1'b1;
    if (t > 0) begin
      j        = t - 1;
      play_len = (song_dur[k] + 1) * TD;
      exp_fn   = song_note[k];
      exp_gate = !song_rest[k];
`ifdef MELODY_SEQ_GAP_EN
      if (j >= play_len - GAP) exp_gate = 1'b0;
`endif
      exp_beat = ((j % TD) == TD - 1);
    end
  endtask

  task automatic model_step(input bit st, input bit sp, input bit le);
    exp_beat = 1'b0;
    exp_done = 1'b0;
    if (sp) begin
      m_run    = 1'b0;
      exp_gate = 1'b0;
      exp_busy = 1'b0;
    end else if (m_run) begin
      if (m_t == song_t - 1) begin
        if (le) begin
          m_t = 0;
        end else begin
          m_run    = 1'b0;
          exp_done = 1'b1;
          exp_gate = 1'b0;
          exp_busy = 1'b0;
        end
      end else begin
        m_t++;
      end
    end else if (st) begin
      m_run = 1'b1;
      m_t   = 0;
    end
    if (m_run) model_outputs();
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".fullnote"}, 32'(sif.fullnote), exp_fn);
    check({ph, ".gate"},     32'(sif.gate),     32'(exp_gate));
    check({ph, ".busy"},     32'(sif.busy),     32'(exp_busy));
    check({ph, ".beat"},     32'(sif.beat),     32'(exp_beat));
    check({ph, ".done"},     32'(sif.done),     32'(exp_done));
  endtask

  task automatic run_cycle(input string ph, input bit st, input bit sp, input bit le);
    sif.start   = st;
    sif.stop    = sp;
    sif.loop_en = le;
    @(posedge clk);
    model_step(st, sp, le);
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic idle_cycles(input string ph, input int n, input bit le);
    for (int i = 0; i < n; i++) run_cycle(ph, 1'b0, 1'b0, le);
  endtask

  // Asynchronous reset between clock edges: outputs must clear before the next edge.
  task automatic async_reset(input string ph);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all({ph, ".async"});
    @(negedge clk);
    compare_all({ph, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    bit le_r;
    bit st, sp;
    song_t = 0;
    for (int i = 0; i < SL; i++) song_t += (song_dur[i] + 1) * TD + 1;
    sif.start   = 1'b0;
    sif.stop    = 1'b0;
    sif.loop_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Single pass, then idle long enough to see done and the return to IDLE.
    idle_cycles("idle", 3, 1'b0);
    run_cycle("s1.start", 1'b1, 1'b0, 1'b0);
    idle_cycles("s1", 24, 1'b0);

    // Looping playback wraps to entry 0 without a done pulse, then stop.
    run_cycle("loop.start", 1'b1, 1'b0, 1'b1);
    idle_cycles("loop", 45, 1'b1);
    run_cycle("loop.stop", 1'b0, 1'b1, 1'b1);
    idle_cycles("loop.after", 3, 1'b0);

    // Stop mid-song, then a fresh start replays from entry 0.
    run_cycle("stop.start", 1'b1, 1'b0, 1'b0);
    idle_cycles("stop", 9, 1'b0);
    run_cycle("stop.hit", 1'b0, 1'b1, 1'b0);
    idle_cycles("stop.idle", 3, 1'b0);
    run_cycle("restart", 1'b1, 1'b0, 1'b0);
    idle_cycles("restart", 24, 1'b0);

    // Start re-pulsed while busy is ignored; start and stop together means stop.
    run_cycle("busy.start", 1'b1, 1'b0, 1'b0);
    idle_cycles("busy", 2, 1'b0);
    run_cycle("busy.restart", 1'b1, 1'b0, 1'b0);
    idle_cycles("busy", 22, 1'b0);
    run_cycle("both.start", 1'b1, 1'b0, 1'b0);
    idle_cycles("both", 4, 1'b0);
    run_cycle("both.hit", 1'b1, 1'b1, 1'b0);
    idle_cycles("both.idle", 2, 1'b0);

    // Asynchronous reset in the middle of PLAY.
    run_cycle("rst.start", 1'b1, 1'b0, 1'b0);
    idle_cycles("rst", 7, 1'b0);
    async_reset("rst");
    idle_cycles("rst.after", 3, 1'b0);
    run_cycle("rst.restart", 1'b1, 1'b0, 1'b0);
    idle_cycles("rst.restart", 24, 1'b0);

    // Random traffic.
    le_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) le_r = ~le_r;
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 49) == 0);
      run_cycle("rand", st, sp, le_r);
      if ($urandom_range(0, 599) == 0) async_reset("rand.rst");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
